// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
// Timekeeping and setting controller for the digital clock.
//
// Keeps hours/minutes/seconds in binary, advanced by a 1 Hz single-cycle
// sec_tick. A RUN -> SET_HOUR -> SET_MIN -> RUN mode machine is stepped by
// the debounced mode_btn pulse. In the set modes, inc_btn bumps the selected
// field and blink toggles once per second so the display can flash that field.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sec_tick   in   one-cycle pulse per second
//   mode_btn   in   one-cycle pulse, advances the mode
//   inc_btn    in   one-cycle pulse, increments the selected field
//   hours      out  0..HOUR_MAX
//   minutes    out  0..59
//   seconds    out  0..59
//   mode       out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   blink      out  display enable for the field being set (1 in RUN)
//   day_pulse  out  one-cycle pulse on HOUR_MAX:59:59 -> 00:00:00
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module clock_ctrl #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_SET_HOUR = 2'b01;
  localparam logic [1:0] MODE_SET_MIN  = 2'b10;

  localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);
  localparam logic [5:0] SIXTY_LAST = 6'd59;

  logic [4:0] hours_q,   hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic [1:0] mode_q,    mode_d;
  logic       blink_q,   blink_d;
  logic       day_pulse_q, day_pulse_d;

  // Next-state computation for time counters, mode machine and blink.
  always_comb begin
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    mode_d      = mode_q;
    blink_d     = blink_q;
    day_pulse_d = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        // The tick is applied even when mode_btn arrives on the same edge.
        if (sec_tick) begin
          if (seconds_q == SIXTY_LAST) begin
            seconds_d = 6'd0;
            if (minutes_q == SIXTY_LAST) begin
              minutes_d = 6'd0;
              if (hours_q == HOUR_LAST) begin
                hours_d     = 5'd0;
                day_pulse_d = 1'b1;
              end else begin
                hours_d = hours_q + 5'd1;
              end
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end else begin
          seconds_d = seconds_q;
        end

        if (mode_btn) begin
          mode_d  = MODE_SET_HOUR;
          blink_d = 1'b1;
        end else begin
          mode_d  = MODE_RUN;
          blink_d = 1'b1;
        end
      end

      MODE_SET_HOUR: begin
        // A mode press wins over both inc_btn and sec_tick.
        if (mode_btn) begin
          mode_d  = MODE_SET_MIN;
          blink_d = 1'b1;
        end else begin
          if (inc_btn) begin
            if (hours_q == HOUR_LAST) begin
              hours_d = 5'd0;
            end else begin
              hours_d = hours_q + 5'd1;
            end
          end else begin
            hours_d = hours_q;
          end
          if (sec_tick) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
          end
        end
      end

      MODE_SET_MIN: begin
        if (mode_btn) begin
          // Returning to RUN restarts the minute from :00.
          mode_d    = MODE_RUN;
          blink_d   = 1'b1;
          seconds_d = 6'd0;
        end else begin
          // Minute wrap deliberately does not carry into hours.
          if (inc_btn) begin
            if (minutes_q == SIXTY_LAST) begin
              minutes_d = 6'd0;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            minutes_d = minutes_q;
          end
          if (sec_tick) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
          end
        end
      end

      default: begin
        // Encoding 11 is unreachable; fall back to RUN.
        mode_d  = MODE_RUN;
        blink_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hours_q     <= 5'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      mode_q      <= MODE_RUN;
      blink_q     <= 1'b1;
      day_pulse_q <= 1'b0;
    end else begin
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      mode_q      <= mode_d;
      blink_q     <= blink_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign mode      = mode_q;
  assign blink     = blink_q;
  assign day_pulse = day_pulse_q;

endmodule
